// File: rtl/serial_add_arbiter.sv
// -----------------------------------------------------------------------------
// serial_add_arbiter
//
// Shares one bit-serial full-adder cell between two requesters. A granted
// requester's operands are captured into shift registers and added LSB-first,
// one bit per clock. The result, its carry-out and the owning requester index
// are presented together with a one-cycle done pulse. Requesters are served
// round-robin; requester 0 wins the first contended grant after reset.
//
// Build option:
//   ADDON_SAT_EN  when defined, a final carry of 1 forces sum to all-ones
//                 (saturating add); cout still reports 1. Ports and timing
//                 are identical either way.
//
// Ports:
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      synchronous active-high reset
//   req      in   2      per-requester add request, held until its gnt
//   a0, b0   in   WIDTH  operands of requester 0
//   a1, b1   in   WIDTH  operands of requester 1
//   gnt      out  2      one-hot one-cycle pulse: operands were captured
//   busy     out  1      high from capture until the cycle after done
//   done     out  1      one-cycle pulse: sum/cout/done_id are new
//   sum      out  WIDTH  last completed result, held until the next done
//   cout     out  1      carry-out of last completed add
//   done_id  out  1      requester that owns the last result
// -----------------------------------------------------------------------------
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_id
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ADDON_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Two cascaded half adders; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic hs1;
    logic hc1;
    logic hs2;
    logic hc2;
    hs1 = a ^ b;
    hc1 = a & b;
    hs2 = hs1 ^ c;
    hc2 = hs1 & c;
    return {hc1 | hc2, hs2};
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic c);
    return (SAT_EN && c) ? {WIDTH{1'b1}} : s;
  endfunction

  // Control state (reset)
  state_t             state_q, state_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               owner_q, owner_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               id_q, id_d;

  // Datapath shift registers (no reset; only meaningful during SHIFT)
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;

  logic               sel;
  logic [1:0]         fa;
  logic [WIDTH-1:0]   shifted_a;

  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    gnt_d     = 2'b00;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    cout_d    = cout_q;
    id_d      = id_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel       = 1'b0;
    fa        = full_add(opa_q[0], opb_q[0], carry_q);
    // The a register doubles as the result accumulator: each sum bit enters
    // at the MSB as the consumed operand bit leaves at the LSB, so after
    // WIDTH shifts it holds the complete sum.
    shifted_a = {fa[0], opa_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // Contention goes to whoever was not granted last.
          sel     = (req == 2'b11) ? ~rr_q : req[1];
          opa_d   = sel ? a1 : a0;
          opb_d   = sel ? b1 : b0;
          carry_d = 1'b0;
          cnt_d   = '0;
          gnt_d   = sel ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          rr_d    = sel;
          owner_d = sel;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        opa_d   = shifted_a;
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = fa[1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = saturate(shifted_a, fa[1]);
          cout_d  = fa[1];
          id_d    = owner_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rr_q    <= 1'b1;
      owner_q <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
    end
  end

  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign done_id = id_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;

  localparam int W = 8;

`ifdef ADDON_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done, cout, done_id;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: index of the last granted requester.
  logic rr_m;

  always #5 clk = ~clk;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .done_id (done_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {cout, sum} of an unsigned add, with optional saturation.
  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (SAT && t[W]) t[W-1:0] = {W{1'b1}};
    return t;
  endfunction

  function automatic logic model_pick(input logic [1:0] r);
    if (r == 2'b11) return ~rr_m;
    return r[1];
  endfunction

  // Drives one request from IDLE and collects what the DUT produced.
  task automatic issue(input logic [1:0] r, output logic [1:0] g, output int lat,
                       output logic [W-1:0] s, output logic c, output logic id,
                       output logic busy_gap, output logic done_gap);
    req = r;
    tick();
    g   = gnt;
    req = r & ~gnt;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    s = sum;
    c = cout;
    id = done_id;
    tick();
    busy_gap = busy;
    done_gap = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b11;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    tick();
    tick();
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (sum !== '0) begin n_bad++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_cmp++; if (done_id !== 1'b0) begin n_bad++; $display("FAIL reset_id: got %b want 0", done_id); end
    rst = 1'b0;
    req = 2'b00;
    rr_m = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00) begin n_bad++; $display("FAIL idle_after_reset: got busy=%b gnt=%b want 0/00", busy, gnt); end
  endtask

  task automatic test_basic();
    logic [1:0] g; int lat; logic [W-1:0] s; logic c, id, bg, dg;
    a0 = 8'h3C; b0 = 8'h0F;
    issue(2'b01, g, lat, s, c, id, bg, dg);
    n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL basic_gnt: got %b want 01", g); end
    n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
    n_cmp++; if (s !== 8'h4B) begin n_bad++; $display("FAIL basic_sum: got %h want 4b", s); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL basic_cout: got %b want 0", c); end
    n_cmp++; if (id !== 1'b0) begin n_bad++; $display("FAIL basic_id: got %b want 0", id); end
    n_cmp++; if (bg !== 1'b0 || dg !== 1'b0) begin n_bad++; $display("FAIL basic_after_done: got busy=%b done=%b want 0/0", bg, dg); end
    rr_m = 1'b0;
  endtask

  task automatic test_overflow();
    logic [1:0] g; int lat; logic [W-1:0] s; logic c, id, bg, dg;
    logic [W-1:0] exp_s;
    exp_s = SAT ? 8'hFF : 8'h00;
    a1 = 8'hFF; b1 = 8'h01;
    issue(2'b10, g, lat, s, c, id, bg, dg);
    n_cmp++; if (g !== 2'b10) begin n_bad++; $display("FAIL ovf_gnt: got %b want 10", g); end
    n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL ovf_sum: got %h want %h", s, exp_s); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL ovf_cout: got %b want 1", c); end
    n_cmp++; if (id !== 1'b1) begin n_bad++; $display("FAIL ovf_id: got %b want 1", id); end
    rr_m = 1'b1;
  endtask

  task automatic test_round_robin();
    int lat;
    logic exp_id;
    logic [W-1:0] exp_s;
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0; rr_m = 1'b1;
    a0 = 8'h10; b0 = 8'h01; a1 = 8'h20; b1 = 8'h02;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_id = (k == 1);
      exp_s  = exp_id ? 8'h22 : 8'h11;
      tick();
      n_cmp++; if (gnt !== (exp_id ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt, exp_id ? 2'b10 : 2'b01); end
      if (k == 2) req = 2'b00;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
      n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL rr_latency_%0d: got %0d want %0d", k, lat, W); end
      n_cmp++; if (done_id !== exp_id) begin n_bad++; $display("FAIL rr_id_%0d: got %b want %b", k, done_id, exp_id); end
      n_cmp++; if (sum !== exp_s) begin n_bad++; $display("FAIL rr_sum_%0d: got %h want %h", k, sum, exp_s); end
      tick();
    end
    rr_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] g; int lat; logic [W-1:0] s; logic c, id, bg, dg;
    logic seen_done;
    a0 = W'($urandom); b0 = W'($urandom);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({gnt, busy, done, sum, cout, done_id} !== '0) begin n_bad++; $display("FAIL midreset_outputs: got gnt=%b busy=%b done=%b sum=%h cout=%b id=%b want all 0", gnt, busy, done, sum, cout, done_id); end
    rst = 1'b0;
    rr_m = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL midreset_no_done: got activity=1 want 0"); end
    a0 = 8'h01; b0 = 8'h01;
    issue(2'b01, g, lat, s, c, id, bg, dg);
    n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL midreset_gnt: got %b want 01", g); end
    n_cmp++; if (s !== 8'h02 || c !== 1'b0 || id !== 1'b0) begin n_bad++; $display("FAIL midreset_sum: got %h/%b/%b want 02/0/0", s, c, id); end
    rr_m = 1'b0;
  endtask

  task automatic test_contention();
    int lat;
    logic stray_gnt;
    logic [W:0] exp0, exp1;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    exp0 = model_add(a0, b0);
    exp1 = model_add(a1, b1);
    req = 2'b01;
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL cont_gnt0: got %b want 01", gnt); end
    req = 2'b10;
    stray_gnt = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick(); lat++;
      if (gnt !== 2'b00) stray_gnt = 1'b1;
    end
    n_cmp++; if (stray_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_no_gnt_in_shift: got stray=1 want 0"); end
    n_cmp++; if ({cout, sum} !== exp0 || done_id !== 1'b0) begin n_bad++; $display("FAIL cont_result0: got %b_%h id=%b want %b_%h id=0", cout, sum, done_id, exp0[W], exp0[W-1:0]); end
    tick();
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00) begin n_bad++; $display("FAIL cont_gap: got busy=%b gnt=%b want 0/00", busy, gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b10 || busy !== 1'b1) begin n_bad++; $display("FAIL cont_gnt1: got gnt=%b busy=%b want 10/1", gnt, busy); end
    req = 2'b00;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_cmp++; if ({cout, sum} !== exp1 || done_id !== 1'b1) begin n_bad++; $display("FAIL cont_result1: got %b_%h id=%b want %b_%h id=1", cout, sum, done_id, exp1[W], exp1[W-1:0]); end
    tick();
    rr_m = 1'b1;
  endtask

  task automatic test_edges();
    logic [1:0] g; int lat; logic [W-1:0] s; logic c, id, bg, dg;
    logic [W-1:0] exp_s;
    logic moved;
    a0 = 8'h00; b0 = 8'h00;
    issue(2'b01, g, lat, s, c, id, bg, dg);
    n_cmp++; if (s !== 8'h00 || c !== 1'b0) begin n_bad++; $display("FAIL edge_zero: got %h/%b want 00/0", s, c); end
    a0 = 8'h80; b0 = 8'h80;
    exp_s = SAT ? 8'hFF : 8'h00;
    issue(2'b01, g, lat, s, c, id, bg, dg);
    n_cmp++; if (s !== exp_s || c !== 1'b1) begin n_bad++; $display("FAIL edge_msb: got %h/%b want %h/1", s, c, exp_s); end
    rr_m = 1'b0;
    // Result must hold through idle cycles and through the next add until its done.
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sum !== exp_s || cout !== 1'b1) moved = 1'b1;
    end
    a1 = 8'h01; b1 = 8'h02;
    req = 2'b10;
    tick();
    req = 2'b00;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (sum !== exp_s || cout !== 1'b1) moved = 1'b1;
      tick(); lat++;
    end
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL edge_hold: got changed=1 want 0"); end
    n_cmp++; if (sum !== 8'h03 || cout !== 1'b0 || done_id !== 1'b1) begin n_bad++; $display("FAIL edge_next: got %h/%b/%b want 03/0/1", sum, cout, done_id); end
    tick();
    rr_m = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] g; int lat; logic [W-1:0] s; logic c, id, bg, dg;
    logic [1:0] hold, exp_g;
    logic exp_id;
    logic [W:0] exp_r;
    hold = 2'b00;
    for (int n = 0; n < 24; n++) begin
      if (hold == 2'b00) begin
        hold = 2'($urandom_range(1, 3));
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      end
      exp_id = model_pick(hold);
      exp_g  = exp_id ? 2'b10 : 2'b01;
      exp_r  = exp_id ? model_add(a1, b1) : model_add(a0, b0);
      issue(hold, g, lat, s, c, id, bg, dg);
      n_cmp++; if (g !== exp_g) begin n_bad++; $display("FAIL rand_gnt_%0d: got %b want %b", n, g, exp_g); end
      n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL rand_latency_%0d: got %0d want %0d", n, lat, W); end
      n_cmp++; if ({c, s} !== exp_r || id !== exp_id) begin n_bad++; $display("FAIL rand_result_%0d: got %b_%h id=%b want %b_%h id=%b", n, c, s, id, exp_r[W], exp_r[W-1:0], exp_id); end
      rr_m = exp_id;
      hold = hold & ~exp_g;
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    rr_m = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_round_robin();
    test_reset_mid();
    test_contention();
    test_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
